// File: rtl/gf_clmul_seq.sv
// Sequential carry-less (GF(2)[x]) multiplier: one bit of B per cycle,
// producing the unreduced 2W-bit product and the clamped field degree.
module gf_clmul_seq #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         a_in,
  input  logic [DATA_WIDTH-1:0]         b_in,
  input  logic [$clog2(DATA_WIDTH):0]   polyn_grade,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*DATA_WIDTH-1:0]       prod_out,
  output logic [$clog2(DATA_WIDTH):0]   grade_out
);

  localparam int W  = DATA_WIDTH;
  localparam int GW = $clog2(DATA_WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [GW-1:0] W_G   = GW'(W);
  localparam logic [GW-1:0] ONE_G = GW'(1);
  localparam logic [GW-1:0] ZERO_G = GW'(0);

  logic [1:0]      state_q, state_d;
  logic [2*W-1:0]  a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [GW-1:0]   n_q, n_d;
  logic [GW-1:0]   grade_q, grade_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [GW-1:0]   m_clamped;
  logic [W-1:0]    op_mask;

  // Clamp the requested degree to W and build the operand mask [m-1:0].
  always_comb begin
    m_clamped = (polyn_grade > W_G) ? W_G : polyn_grade;
    op_mask   = {W{1'b0}};
    for (int i = 0; i < W; i++) begin
      op_mask[i] = (GW'(i) < m_clamped);
    end
  end

  // Next-state logic for the IDLE/RUN/DONE sequencer and datapath.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    n_d     = n_q;
    grade_d = grade_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = {{W{1'b0}}, a_in & op_mask};
          b_d     = b_in & op_mask;
          acc_d   = {(2*W){1'b0}};
          n_d     = m_clamped;
          grade_d = m_clamped;
          state_d = (m_clamped == ZERO_G) ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (b_q[0]) begin
          acc_d = acc_q ^ a_q;
        end else begin
          acc_d = acc_q;
        end
        a_d = a_q << 1;
        b_d = b_q >> 1;
        n_d = n_q - ONE_G;
        // n_q of zero in RUN is unreachable; leave toward DONE rather than wrap.
        if (n_q <= ONE_G) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= {(2*W){1'b0}};
      b_q         <= {W{1'b0}};
      acc_q       <= {(2*W){1'b0}};
      n_q         <= ZERO_G;
      grade_q     <= ZERO_G;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      n_q         <= n_d;
      grade_q     <= grade_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign prod_out  = acc_q;
  assign grade_out = grade_q;

endmodule
